// File: rtl/pcie_rx_completion_if.sv
// RX TLP stream in, read-completion words and error status out, for the CplD parser.
// master drives the RX beats and observes completions; slave is the parser itself.
interface pcie_rx_completion_if #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned ERR_BITS   = 16
);
    logic                  rx_valid;
    logic                  rx_sop;
    logic                  rx_eop;
    logic [63:0]           rx_data;

    logic                  rc_valid;
    logic [7:0]            rc_tag;
    logic [INDEX_BITS-1:0] rc_index;
    logic [63:0]           rc_data;
    logic                  cpl_error;
    logic [ERR_BITS-1:0]   err_count;

    modport master (
        output rx_valid,
        output rx_sop,
        output rx_eop,
        output rx_data,
        input  rc_valid,
        input  rc_tag,
        input  rc_index,
        input  rc_data,
        input  cpl_error,
        input  err_count
    );

    modport slave (
        input  rx_valid,
        input  rx_sop,
        input  rx_eop,
        input  rx_data,
        output rc_valid,
        output rc_tag,
        output rc_index,
        output rc_data,
        output cpl_error,
        output err_count
    );
endinterface

// File: rtl/pcie_rx_completion.sv
// CplD receive parser: strips the 3DW header, realigns the payload into 64-bit words and
// labels each word with its position in the request block, derived from the byte count.
module pcie_rx_completion #(
    parameter int unsigned REQ_BYTES  = 512,
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned ERR_BITS   = 16
) (
    input logic                 clock,
    input logic                 reset_n,
    pcie_rx_completion_if.slave bus
);

    localparam logic [12:0] ReqBytes = 13'(REQ_BYTES);

    typedef enum logic [1:0] {
        StIdle,
        StHdr2,
        StData,
        StDrop
    } state_e;

    state_e state_q, state_d;

    logic [31:0]           held_q, held_d;
    logic [7:0]            tag_q, tag_d;
    logic [8:0]            words_left_q, words_left_d;
    logic [INDEX_BITS-1:0] index_q, index_d;

    logic                  rc_valid_q;
    logic [7:0]            rc_tag_q;
    logic [INDEX_BITS-1:0] rc_index_q;
    logic [63:0]           rc_data_q;
    logic                  cpl_error_q;
    logic [ERR_BITS-1:0]   err_count_q;

    logic emit;
    logic err_pulse;

    logic                  sop_beat;
    logic                  data_beat;
    logic                  eop;
    logic                  is_cpld;
    logic                  hdr_ok;
    logic                  in_cpl;
    logic                  last_word;
    logic [9:0]            hdr_length;
    logic [2:0]            hdr_status;
    logic [12:0]           byte_count;
    logic [12:0]           len_bytes;
    logic [INDEX_BITS-1:0] start_index;

    assign sop_beat  = bus.rx_valid & bus.rx_sop;
    assign data_beat = bus.rx_valid & ~bus.rx_sop;
    assign eop       = bus.rx_eop;

    // Header fields are only meaningful on a sop beat (DW0 low, DW1 high).
    assign hdr_length = bus.rx_data[9:0];
    assign hdr_status = bus.rx_data[47:45];
    assign byte_count = (bus.rx_data[43:32] == 12'd0) ? 13'd4096 : {1'b0, bus.rx_data[43:32]};
    assign len_bytes  = {1'b0, hdr_length, 2'b00};

    assign is_cpld = (bus.rx_data[30:29] == 2'b10) && (bus.rx_data[28:24] == 5'b01010);
    assign hdr_ok  = (hdr_status == 3'd0) && !hdr_length[0] && (hdr_length != 10'd0) &&
                     (len_bytes <= byte_count) && (byte_count <= ReqBytes);

    // Bytes already delivered by earlier completions fix where this one starts.
    assign start_index = INDEX_BITS'((ReqBytes - byte_count) >> 3);

    assign in_cpl    = (state_q == StHdr2) || (state_q == StData);
    assign last_word = (words_left_q == 9'd1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sop_beat) begin
            if (eop) begin
                state_d = StIdle;
            end else if (is_cpld && hdr_ok) begin
                state_d = StHdr2;
            end else begin
                state_d = StDrop;
            end
        end else if (data_beat) begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StHdr2: state_d = eop ? StIdle : StData;
                StData: begin
                    if (eop) begin
                        state_d = StIdle;
                    end else if (last_word) begin
                        state_d = StDrop;
                    end
                end
                StDrop: begin
                    if (eop) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        emit         = 1'b0;
        err_pulse    = 1'b0;
        held_d       = held_q;
        tag_d        = tag_q;
        words_left_d = words_left_q;
        index_d      = index_q;
        if (sop_beat) begin
            // A sop cuts short any completion still in flight.
            err_pulse    = in_cpl | (is_cpld & (~hdr_ok | eop));
            words_left_d = hdr_length[9:1];
            index_d      = start_index;
        end else if (data_beat) begin
            unique case (state_q)
                StHdr2: begin
                    tag_d     = bus.rx_data[15:8];
                    held_d    = bus.rx_data[63:32];
                    err_pulse = eop;
                end
                StData: begin
                    emit         = 1'b1;
                    held_d       = bus.rx_data[63:32];
                    words_left_d = words_left_q - 9'd1;
                    index_d      = index_q + INDEX_BITS'(1);
                    // Early eop or missing eop on the final word are both faults.
                    err_pulse    = eop ^ last_word;
                end
                default: begin
                    emit = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            held_q       <= '0;
            tag_q        <= '0;
            words_left_q <= '0;
            index_q      <= '0;
            rc_valid_q   <= 1'b0;
            rc_tag_q     <= '0;
            rc_index_q   <= '0;
            rc_data_q    <= '0;
            cpl_error_q  <= 1'b0;
            err_count_q  <= '0;
        end else begin
            held_q       <= held_d;
            tag_q        <= tag_d;
            words_left_q <= words_left_d;
            index_q      <= index_d;
            rc_valid_q   <= emit;
            if (emit) begin
                rc_tag_q   <= tag_q;
                rc_index_q <= index_q;
                rc_data_q  <= {bus.rx_data[31:0], held_q};
            end
            cpl_error_q <= err_pulse;
            if (err_pulse && !(&err_count_q)) begin
                err_count_q <= err_count_q + ERR_BITS'(1);
            end
        end
    end

    assign bus.rc_valid  = rc_valid_q;
    assign bus.rc_tag    = rc_tag_q;
    assign bus.rc_index  = rc_index_q;
    assign bus.rc_data   = rc_data_q;
    assign bus.cpl_error = cpl_error_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_pcie_rx_completion.sv
// Directed bench for pcie_rx_completion: each TLP's expected words and error pulses are
// derived from its header fields and beat count, then compared against the DUT every cycle.
module tb_pcie_rx_completion;

    logic clock;
    logic reset_n;

    pcie_rx_completion_if #(.INDEX_BITS(6), .ERR_BITS(16)) bus ();

    pcie_rx_completion #(
        .REQ_BYTES (512),
        .INDEX_BITS(6),
        .ERR_BITS  (16)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        bit        v;
        bit [7:0]  tag;
        bit [5:0]  idx;
        bit [63:0] data;
        bit        err;
    } exp_t;

    exp_t exp_cur;
    exp_t exp_seen;
    exp_t exp_none;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    bit pending_trunc = 0;

    logic [31:0] tlp[$];
    logic [5:0]  obs_idx[$];
    logic [63:0] obs_data[$];
    logic [7:0]  obs_tag[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Model pipeline: the beat driven in a cycle decides the outputs seen after the next edge.
    always @(posedge clock) begin
        if (!reset_n) begin
            exp_seen  = exp_none;
            model_cnt = 0;
        end else begin
            exp_seen = exp_cur;
            if (exp_cur.err && model_cnt < 65535) model_cnt++;
        end
    end

    always @(negedge clock) begin
        if (!reset_n) begin
            check("reset rc_valid", 64'(bus.rc_valid), 64'd0);
            check("reset rc_tag", 64'(bus.rc_tag), 64'd0);
            check("reset rc_index", 64'(bus.rc_index), 64'd0);
            check("reset rc_data", bus.rc_data, 64'd0);
            check("reset cpl_error", 64'(bus.cpl_error), 64'd0);
            check("reset err_count", 64'(bus.err_count), 64'd0);
        end else begin
            check("rc_valid", 64'(bus.rc_valid), 64'(exp_seen.v));
            if (exp_seen.v) begin
                check("rc_tag", 64'(bus.rc_tag), 64'(exp_seen.tag));
                check("rc_index", 64'(bus.rc_index), 64'(exp_seen.idx));
                check("rc_data", bus.rc_data, exp_seen.data);
            end
            check("cpl_error", 64'(bus.cpl_error), 64'(exp_seen.err));
            check("err_count", 64'(bus.err_count), 64'(model_cnt));
            if (bus.rc_valid) begin
                obs_idx.push_back(bus.rc_index);
                obs_data.push_back(bus.rc_data);
                obs_tag.push_back(bus.rc_tag);
            end
        end
    end

    task automatic drive(input bit v, input bit s, input bit e, input logic [63:0] d,
                         input exp_t x);
        @(posedge clock);
        #1;
        bus.rx_valid = v;
        bus.rx_sop   = s;
        bus.rx_eop   = e;
        bus.rx_data  = d;
        exp_cur      = x;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 64'd0, exp_none);
    endtask

    task automatic clear_obs();
        obs_idx.delete();
        obs_data.delete();
        obs_tag.delete();
    endtask

    task automatic make_cpld(input logic [7:0] tag, input logic [9:0] len, input logic [11:0] bc,
                             input logic [2:0] status, input int base, input int npay);
        tlp.delete();
        tlp.push_back({1'b0, 2'b10, 5'b01010, 14'd0, len});
        tlp.push_back({16'h0100, status, 1'b0, bc});
        tlp.push_back({16'h0000, tag, 8'h00});
        for (int i = 0; i < npay; i++) tlp.push_back(32'(base + i));
    endtask

    // Sends tlp[] two DWs per beat; eop on the last beat only if send_eop.
    task automatic send_tlp(input bit gaps, input bit send_eop);
        int          n, nb, len, bc, words, e_beat, start;
        bit          cpld, ok;
        logic [31:0] h0, h1, h2, lo, hi;
        logic [7:0]  tag;
        exp_t        x;
        n      = tlp.size();
        nb     = (n + 1) / 2;
        h0     = tlp[0];
        h1     = tlp[1];
        h2     = (n > 2) ? tlp[2] : 32'd0;
        cpld   = (h0[30:29] == 2'b10) && (h0[28:24] == 5'b01010);
        len    = int'(h0[9:0]);
        bc     = (h1[11:0] == 12'd0) ? 4096 : int'(h1[11:0]);
        ok     = cpld && (h1[15:13] == 3'd0) && (len % 2 == 0) && (len > 0) &&
                 (len * 4 <= bc) && (bc <= 512);
        words  = len / 2;
        e_beat = words + 1;  // sop beat, DW2 beat, then one beat per word
        start  = ok ? (512 - bc) / 8 : 0;
        tag    = h2[15:8];
        for (int b = 0; b < nb; b++) begin
            bit eop_b;
            int m;
            lo    = tlp[2*b];
            hi    = (2 * b + 1 < n) ? tlp[2*b+1] : 32'd0;
            eop_b = send_eop && (b == nb - 1);
            x     = exp_none;
            m     = b - 2;
            if (ok && m >= 0 && m < words) begin
                x.v    = 1'b1;
                x.tag  = tag;
                x.idx  = 6'((start + m) % 64);
                x.data = {tlp[3+2*m+1], tlp[3+2*m]};
            end
            if (b == 0 && pending_trunc) x.err = 1'b1;
            if (b == 0 && cpld && !ok) x.err = 1'b1;
            if (ok && eop_b && b < e_beat) x.err = 1'b1;
            if (ok && b == e_beat && !eop_b) x.err = 1'b1;
            drive(1'b1, b == 0, eop_b, {hi, lo}, x);
            if (gaps) drive(1'b0, 1'b1, 1'b1, {$urandom, $urandom}, exp_none);
        end
        pending_trunc = ok && !send_eop && (nb - 1 < e_beat);
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_sop   = 1'b0;
        bus.rx_eop   = 1'b0;
        bus.rx_data  = 64'd0;
        exp_cur      = exp_none;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        idle(2);
        check("post-reset err_count", 64'(bus.err_count), 64'd0);

        // Single 512B completion
        clear_obs();
        make_cpld(8'd3, 10'd128, 12'd512, 3'd0, 0, 128);
        send_tlp(1'b0, 1'b1);
        idle(3);
        check("t1 word count", 64'(obs_data.size()), 64'd64);
        check("t1 last index", 64'(obs_idx[63]), 64'd63);
        check("t1 last data", obs_data[63], 64'h0000007F_0000007E);
        check("t1 tag", 64'(obs_tag[0]), 64'd3);

        // Same block as four 32DW completions
        clear_obs();
        for (int k = 0; k < 4; k++) begin
            make_cpld(8'd3, 10'd32, 12'(512 - 128 * k), 3'd0, 32 * k, 32);
            send_tlp(1'b0, 1'b1);
        end
        idle(3);
        check("t2 word count", 64'(obs_data.size()), 64'd64);
        check("t2 index 16", 64'(obs_idx[16]), 64'd16);
        check("t2 index 48", 64'(obs_idx[48]), 64'd48);
        check("t2 data 32", obs_data[32], 64'h00000041_00000040);

        // Test 1 with rx_valid low every other cycle
        clear_obs();
        make_cpld(8'd3, 10'd128, 12'd512, 3'd0, 0, 128);
        send_tlp(1'b1, 1'b1);
        idle(3);
        check("t3 word count", 64'(obs_data.size()), 64'd64);
        check("t3 data 10", obs_data[10], 64'h00000015_00000014);

        // MWr is dropped silently, UR completion is rejected
        clear_obs();
        tlp.delete();
        tlp.push_back({1'b0, 2'b11, 5'b00000, 14'd0, 10'd4});
        tlp.push_back(32'h0000_00FF);
        tlp.push_back(32'h0000_0000);
        tlp.push_back(32'h0000_1000);
        for (int i = 0; i < 4; i++) tlp.push_back(32'hA5A5_0000 + 32'(i));
        send_tlp(1'b0, 1'b1);
        make_cpld(8'd4, 10'd4, 12'd16, 3'b001, 0, 4);
        send_tlp(1'b0, 1'b1);
        idle(3);
        check("t4 word count", 64'(obs_data.size()), 64'd0);
        check("t4 err_count", 64'(bus.err_count), 64'd1);

        // 16DW completion with eop on the 4th beat after the header
        clear_obs();
        make_cpld(8'd7, 10'd16, 12'd64, 3'd0, 0, 7);
        send_tlp(1'b0, 1'b1);
        idle(3);
        check("t5 word count", 64'(obs_data.size()), 64'd3);
        check("t5 first index", 64'(obs_idx[0]), 64'd56);
        check("t5 err_count", 64'(bus.err_count), 64'd2);

        // Reset in the middle of a following completion
        make_cpld(8'd9, 10'd8, 12'd32, 3'd0, 200, 8);
        while (tlp.size() > 4) void'(tlp.pop_back());
        send_tlp(1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset_n       = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_sop    = 1'b0;
        bus.rx_eop    = 1'b0;
        bus.rx_data   = 64'd0;
        exp_cur       = exp_none;
        pending_trunc = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("in-reset rc_valid", 64'(bus.rc_valid), 64'd0);
        check("in-reset err_count", 64'(bus.err_count), 64'd0);
        reset_n = 1'b1;
        idle(1);
        clear_obs();
        make_cpld(8'd5, 10'd8, 12'd32, 3'd0, 100, 8);
        send_tlp(1'b0, 1'b1);
        idle(3);
        check("t5b word count", 64'(obs_data.size()), 64'd4);
        check("t5b first index", 64'(obs_idx[0]), 64'd60);
        check("t5b last data", obs_data[3], 64'h0000006B_0000006A);
        check("t5b tag", 64'(obs_tag[3]), 64'd5);

        // A new sop truncates a completion still in DATA
        clear_obs();
        make_cpld(8'd1, 10'd8, 12'd64, 3'd0, 0, 8);
        while (tlp.size() > 6) void'(tlp.pop_back());
        send_tlp(1'b0, 1'b0);
        make_cpld(8'd2, 10'd4, 12'd32, 3'd0, 50, 4);
        send_tlp(1'b0, 1'b1);
        idle(3);
        check("t6 word count", 64'(obs_data.size()), 64'd3);
        check("t6 second start", 64'(obs_idx[1]), 64'd60);
        check("t6 last data", obs_data[2], 64'h00000035_00000034);
        check("t6 err_count", 64'(bus.err_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
